// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops with registered outputs,
// plus iterative unsigned multiply (shift-add) and divide (restoring) into hi/lo.
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zf,
   output logic             of,
   output logic             dz,
   output logic             busy,
   output logic             done
);

   localparam int CW = SHW + 1;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_XOR   = 4'd2;
   localparam logic [3:0] OP_NOR   = 4'd3;
   localparam logic [3:0] OP_ADD   = 4'd4;
   localparam logic [3:0] OP_SUB   = 4'd5;
   localparam logic [3:0] OP_SLT   = 4'd6;
   localparam logic [3:0] OP_SLL   = 4'd7;
   localparam logic [3:0] OP_SRL   = 4'd8;
   localparam logic [3:0] OP_SRA   = 4'd9;
   localparam logic [3:0] OP_MULTU = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd11;

   typedef enum logic {IDLE, ITER} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               zf_q, zf_d;
   logic               of_q, of_d;
   logic               dz_q, dz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_of;
   logic [WIDTH-1:0]   sum, diff;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, step;

   // NOTE: every combinational output is given a default first so no path
   // through the case statements can leave it unassigned and infer a latch.
   always_comb begin
      alu_res = '0;
      alu_of  = 1'b0;
      sum     = a + b;
      diff    = a - b;
      case (op)
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOR: alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum;
            alu_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_of  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: alu_res = b << a[SHW-1:0];
         OP_SRL: alu_res = b >> a[SHW-1:0];
         OP_SRA: alu_res = $signed(b) >>> a[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   // acc holds {partial product, multiplier} for MULTU and {remainder, dividend} for DIVU
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
      step      = is_div_q ? div_next : mul_next;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      result_d = result_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      zf_d     = zf_q;
      of_d     = of_q;
      dz_d     = dz_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (op == OP_MULTU || op == OP_DIVU) begin
                  state_d  = ITER;
                  cnt_d    = CW'(WIDTH);
                  acc_d    = {{WIDTH{1'b0}}, a};
                  opnd_d   = b;
                  is_div_d = (op == OP_DIVU);
                  busy_d   = 1'b1;
               end else begin
                  result_d = alu_res;
                  zf_d     = (alu_res == '0);
                  of_d     = alu_of;
                  dz_d     = 1'b0;
                  done_d   = 1'b1;
               end
            end
         end
         ITER: begin
            acc_d = step;
            cnt_d = cnt_q - CW'(1);
            // The last iteration's result is written on the same edge that returns to IDLE
            if (cnt_q == CW'(1)) begin
               state_d  = IDLE;
               busy_d   = 1'b0;
               hi_d     = step[2*WIDTH-1:WIDTH];
               lo_d     = step[WIDTH-1:0];
               result_d = step[WIDTH-1:0];
               zf_d     = (step[WIDTH-1:0] == '0);
               of_d     = 1'b0;
               dz_d     = is_div_q && (opnd_q == '0);
               done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         result_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         zf_q     <= 1'b1;
         of_q     <= 1'b0;
         dz_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         zf_q     <= zf_d;
         of_q     <= of_d;
         dz_q     <= dz_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign result = result_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign zf     = zf_q;
   assign of     = of_q;
   assign dz     = dz_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: 32-bit and 8-bit instances driven with directed
// and random ops, each completion compared against an arithmetic reference model.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;

   logic        start32, start8;
   logic [3:0]  op32, op8;
   logic [31:0] a32, b32, result32, hi32, lo32;
   logic [7:0]  a8, b8, result8, hi8, lo8;
   logic        zf32, of32, dz32, busy32, done32;
   logic        zf8, of8, dz8, busy8, done8;

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
      .result(result32), .hi(hi32), .lo(lo32), .zf(zf32), .of(of32), .dz(dz32),
      .busy(busy32), .done(done32)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .result(result8), .hi(hi8), .lo(lo8), .zf(zf8), .of(of8), .dz(dz8),
      .busy(busy8), .done(done8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint unsigned r;
      longint unsigned hi;
      longint unsigned lo;
      bit              zf;
      bit              of;
      bit              dz;
   } exp_t;

   exp_t            q32[$];
   exp_t            q8[$];
   longint unsigned mhi32, mlo32, mhi8, mlo8;
   int              n_cmp;
   int              n_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic longint to_signed(input longint unsigned v, input int w);
      longint unsigned sb = 64'd1 << (w - 1);
      if ((v & sb) != 0) return longint'(v) - longint'(64'd1 << w);
      return longint'(v);
   endfunction

   // Reference model straight from the op-code table, using 64-bit arithmetic
   function automatic exp_t model(input int w, input logic [3:0] op, input longint unsigned x,
                                  input longint unsigned y, input longint unsigned phi,
                                  input longint unsigned plo);
      exp_t            e;
      longint unsigned mask = (64'd1 << w) - 1;
      longint unsigned sb   = 64'd1 << (w - 1);
      int              sh   = int'(x % longint'(w));
      longint          sy;
      longint unsigned p;
      e.hi = phi; e.lo = plo; e.of = 0; e.dz = 0; e.r = 0;
      case (op)
         4'd0: e.r = x & y;
         4'd1: e.r = x | y;
         4'd2: e.r = x ^ y;
         4'd3: e.r = ~(x | y) & mask;
         4'd4: begin
            e.r  = (x + y) & mask;
            e.of = ((x ^ y) & sb) == 0 && ((e.r ^ x) & sb) != 0;
         end
         4'd5: begin
            e.r  = (x - y) & mask;
            e.of = ((x ^ y) & sb) != 0 && ((e.r ^ x) & sb) != 0;
         end
         4'd6: e.r = (to_signed(x, w) < to_signed(y, w)) ? 1 : 0;
         4'd7: e.r = (y << sh) & mask;
         4'd8: e.r = y >> sh;
         4'd9: begin
            sy  = to_signed(y, w);
            e.r = longint'(sy >>> sh) & mask;
         end
         4'd10: begin
            p    = x * y;
            e.hi = p >> w;
            e.lo = p & mask;
            e.r  = e.lo;
         end
         4'd11: begin
            if (y == 0) begin
               e.lo = mask; e.hi = x; e.dz = 1;
            end else begin
               e.lo = x / y; e.hi = x % y;
            end
            e.r = e.lo;
         end
         default: e.r = 0;
      endcase
      e.zf = (e.r == 0);
      return e;
   endfunction

   // Monitor: pop one expectation per completion pulse
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done32) begin
            if (q32.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done32_unexpected: got done=1, expected no completion");
            end else begin
               e = q32.pop_front();
               check("result32", {32'd0, result32}, e.r);
               check("hi32", {32'd0, hi32}, e.hi);
               check("lo32", {32'd0, lo32}, e.lo);
               check("zf32", {63'd0, zf32}, {63'd0, e.zf});
               check("of32", {63'd0, of32}, {63'd0, e.of});
               check("dz32", {63'd0, dz32}, {63'd0, e.dz});
            end
         end
         if (done8) begin
            if (q8.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL done8_unexpected: got done=1, expected no completion");
            end else begin
               e = q8.pop_front();
               check("result8", {56'd0, result8}, e.r);
               check("hi8", {56'd0, hi8}, e.hi);
               check("lo8", {56'd0, lo8}, e.lo);
               check("zf8", {63'd0, zf8}, {63'd0, e.zf});
               check("of8", {63'd0, of8}, {63'd0, e.of});
               check("dz8", {63'd0, dz8}, {63'd0, e.dz});
            end
         end
      end
   end

   // Called just after a negedge; returns at the negedge where the op's done is visible
   task automatic issue(input bit w8, input logic [3:0] o, input longint unsigned x,
                        input longint unsigned y, input bit inject);
      exp_t e;
      int   cnt;
      int   w = w8 ? 8 : 32;
      longint unsigned mask = (64'd1 << w) - 1;
      x = x & mask;
      y = y & mask;
      if (w8) begin
         e = model(w, o, x, y, mhi8, mlo8);
         q8.push_back(e); mhi8 = e.hi; mlo8 = e.lo;
         start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
      end else begin
         e = model(w, o, x, y, mhi32, mlo32);
         q32.push_back(e); mhi32 = e.hi; mlo32 = e.lo;
         start32 = 1'b1; op32 = o; a32 = x[31:0]; b32 = y[31:0];
      end
      @(negedge clk);
      start8  = 1'b0;
      start32 = 1'b0;
      if (o == 4'd10 || o == 4'd11) begin
         cnt = 0;
         while ((w8 ? busy8 : busy32) && cnt < 200) begin
            cnt++;
            if (!w8 && inject) begin
               start32 = (cnt == 5);
               op32 = 4'd4; a32 = 32'd1; b32 = 32'd1;
            end
            @(negedge clk);
         end
         start32 = 1'b0;
         check(w8 ? "busy8_cycles" : "busy32_cycles", 64'(cnt), 64'(w));
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      mhi32 = 0; mlo32 = 0; mhi8 = 0; mlo8 = 0;
      start32 = 0; op32 = 0; a32 = 0; b32 = 0;
      start8 = 0; op8 = 0; a8 = 0; b8 = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_result32", {32'd0, result32}, 0);
      check("rst_hi32", {32'd0, hi32}, 0);
      check("rst_lo32", {32'd0, lo32}, 0);
      check("rst_flags32", {59'd0, zf32, of32, dz32, busy32, done32}, 64'b10000);
      check("rst_flags8", {59'd0, zf8, of8, dz8, busy8, done8}, 64'b10000);
      rst_n = 1'b1;
      @(negedge clk);

      issue(0, 4'd4, 64'h7FFF_FFFF, 64'd1, 0);
      @(negedge clk);
      check("done32_one_cycle", {63'd0, done32}, 0);
      issue(0, 4'd5, 64'd5, 64'd5, 0);
      issue(0, 4'd6, 64'hFFFF_FFFF, 64'd1, 0);
      issue(0, 4'd9, 64'd4, 64'h8000_0000, 0);
      issue(0, 4'd7, 64'd33, 64'd1, 0);
      issue(0, 4'd10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1);
      issue(0, 4'd11, 64'd100, 64'd7, 0);
      issue(0, 4'd11, 64'd9, 64'd0, 0);
      issue(0, 4'd0, 64'($urandom), 64'($urandom), 0);
      issue(0, 4'd13, 64'($urandom), 64'($urandom), 0);

      issue(1, 4'd10, 64'hFF, 64'h02, 0);
      issue(1, 4'd4, 64'h80, 64'h80, 0);

      for (int i = 0; i < 150; i++) begin
         logic [3:0] o;
         o = 4'($urandom_range(0, 15));
         issue(0, o, 64'($urandom), ($urandom_range(0, 9) == 0) ? 64'($urandom_range(0, 3))
                                                              : 64'($urandom), 0);
      end
      for (int i = 0; i < 60; i++) begin
         logic [3:0] o;
         o = 4'($urandom_range(0, 15));
         issue(1, o, 64'($urandom), 64'($urandom_range(0, 255)), 0);
      end
      repeat (3) @(negedge clk);

      // Abort a multiply with reset at cycle 10
      start32 = 1'b1; op32 = 4'd10; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0;
      @(negedge clk);
      start32 = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy32}, 0);
      check("abort_hi", {32'd0, hi32}, 0);
      check("abort_lo", {32'd0, lo32}, 0);
      check("abort_zf_done", {62'd0, zf32, done32}, 64'b10);
      mhi32 = 0; mlo32 = 0; mhi8 = 0; mlo8 = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(0, 4'd11, 64'd10, 64'd3, 0);
      repeat (3) @(negedge clk);

      check("q32_drained", 64'(q32.size()), 0);
      check("q8_drained", 64'(q8.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
